// File: rtl/seq_detect_mealy.sv
// Parametrised Mealy serial-pattern detector with overlap/non-overlap mode, qualifier and clear.
// Optional saturating match counter is compiled in with `define SEQDET_COUNT_EN.
module seq_detect_mealy #(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b101,
    parameter int               CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       x,
    input  logic                       in_valid,
    input  logic                       overlap,
    input  logic                       clear,
    output logic                       y,
    output logic [$clog2(PAT_W)-1:0]   progress
`ifdef SEQDET_COUNT_EN
    ,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       cnt_sat
`endif
);

    localparam int SW = $clog2(PAT_W);
    localparam logic [SW-1:0] LAST = SW'(PAT_W - 1);

    if (PAT_W < 2 || PAT_W > 32) begin : g_bad_width
        $error("seq_detect_mealy: PAT_W=%0d outside legal range 2..32", PAT_W);
    end

    // Longest prefix of PATTERN (shorter than PAT_W) that is a suffix of
    // (first p pattern bits followed by b). Evaluated only on constants.
    function automatic logic [SW-1:0] next_p(input int p, input logic b);
        int   best;
        int   si;
        logic ok;
        logic sb;
        best = 0;
        for (int k = 1; k < PAT_W; k++) begin
            if (k <= p + 1) begin
                ok = 1'b1;
                for (int j = 0; j < PAT_W; j++) begin
                    if (j < k) begin
                        si = p + 1 - k + j;
                        sb = (si == p) ? b : PATTERN[PAT_W-1-si];
                        if (sb != PATTERN[PAT_W-1-j]) ok = 1'b0;
                    end
                end
                if (ok) best = k;
            end
        end
        return best[SW-1:0];
    endfunction

    logic [SW-1:0] nxt_tbl [PAT_W][2];

    for (genvar p = 0; p < PAT_W; p++) begin : g_row
        for (genvar b = 0; b < 2; b++) begin : g_col
            assign nxt_tbl[p][b] = next_p(p, 1'(b));
        end
    end

    logic          accept;
    logic          match;
    logic [SW-1:0] prog_nxt;

    assign accept = in_valid & ~clear;
    assign match  = accept && (progress == LAST) && (x == PATTERN[0]);
    assign y      = match & rst_n;

    always_comb begin
        prog_nxt = progress;
        if (clear)
            prog_nxt = '0;
        else if (accept)
            // At a match the table entry for (LAST, PATTERN[0]) is the pattern's own border.
            prog_nxt = (match && !overlap) ? '0 : nxt_tbl[progress][x];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) progress <= '0;
        else        progress <= prog_nxt;
    end

`ifdef SEQDET_COUNT_EN
    assign cnt_sat = &match_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            match_cnt <= '0;
        else if (clear)
            match_cnt <= '0;
        else if (y && !cnt_sat)
            match_cnt <= match_cnt + 1'b1;
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: doc/seq_detect_mealy.md
# seq_detect_mealy

Parametrised Mealy serial-pattern detector. It generalises the fixed 3-bit "101" overlapping detector to any pattern of 2–32 bits. It adds a run-time overlap/non-overlap mode, an input qualifier, a synchronous clear, a progress output and an optional saturating match counter. It sits on a one-bit serial data path and flags a match in the same cycle as the final pattern bit.

## Interface
Parameters:
- PAT_W, default 3: pattern length in bits; legal range 2..32.
- PATTERN, default 3'b101: PAT_W-bit pattern. Bit PAT_W-1 is the first bit received; bit 0 is the last.
- CNT_W, default 8: match-counter width; used only with SEQDET_COUNT_EN.

Ports:
- clk, input, 1: clock; all state is updated on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- x, input, 1: serial data bit.
- in_valid, input, 1: x is accepted this cycle only when in_valid=1.
- overlap, input, 1: 1 selects overlapping detection, 0 selects non-overlapping; sampled on each accepted bit.
- clear, input, 1: synchronous clear of progress and counter.
- y, output, 1: Mealy match flag, combinational from the current state and the inputs.
- progress, output, $clog2(PAT_W): current progress state (registered).
- match_cnt, output, CNT_W: saturating count of matches; only present with SEQDET_COUNT_EN.
- cnt_sat, output, 1: high when match_cnt equals all-ones; only present with SEQDET_COUNT_EN.

## Operation
- State definition: progress P is the length of the longest proper prefix of PATTERN that equals a suffix of the bits accepted since the last restart point. Range is 0..PAT_W-1.
- Restart points are reset, clear, and a match taken in non-overlap mode.
- Next state is derived from P and x, using a prefix table or an equivalent history register. Either is acceptable if the observable y and progress outputs are identical.
- Match condition: in_valid=1, clear=0, P=PAT_W-1, and x equals PATTERN[0]. In that case y=1; otherwise y=0.
- On a match with overlap=1: P moves to the longest proper prefix of PATTERN that is also a suffix of PATTERN. For PATTERN 101 this is 1; for 1101 it is 1.
- On a match with overlap=0: P moves to 0.
- On a non-match accepted bit: P moves to the standard failure transition, i.e. the longest prefix of PATTERN that is a suffix of the accepted history.
- in_valid=0: P holds and y=0, whatever x is.
- clear=1: y=0, P becomes 0 and match_cnt becomes 0. clear takes priority over in_valid, so a bit presented with clear is discarded.
- Counter: match_cnt increments by 1 on each cycle where y=1. At all-ones it holds; it does not wrap.
- Elaboration check: PAT_W outside 2..32 is a configuration error and must be flagged with $error.

## Timing
- y is combinational from P, x, in_valid and clear: zero latency, asserted in the same cycle as the final pattern bit. There is no registered copy.
- progress and match_cnt update on the rising edge after the accepted bit.
- Reset values:
  - progress = 0
  - match_cnt = 0
  - cnt_sat = 0
  - y = 0 while rst_n=0, regardless of inputs.
- Reset asserted mid-sequence discards partial progress immediately. The first bit accepted after deassertion starts from P=0.
- overlap may change on any cycle. The value present on the matching cycle decides the post-match state.
- Simultaneous match and counter at all-ones: y=1, match_cnt holds, cnt_sat stays 1.

## Configuration
- SEQDET_COUNT_EN defined: match_cnt and cnt_sat ports and the counter logic are compiled in, with behaviour as above.
- SEQDET_COUNT_EN undefined: both ports and the counter logic are absent; the rest of the behaviour is unchanged. CNT_W is ignored.

## Test plan
- Default parameters, overlap=1, in_valid=1, bits 1,0,1,0,1 → y=1 on bits 3 and 5; progress after bit 5 = 1.
- Default parameters, overlap=0, bits 1,0,1,0,1 then 1,0,1,1,0,1 → y=1 on bit 3 only in the first stream; y=1 on bits 3 and 6 in the second stream.
- PATTERN=4'b1101, PAT_W=4, overlap=1, bits 1,1,0,1,1,0,1 → y=1 on bits 4 and 7. Repeat with in_valid=0 idle cycles between every bit carrying x=1: same matches, y=0 and progress unchanged on idle cycles.
- Default parameters, bits 1,0 then clear=1 with x=1, in_valid=1, then bit 1 → no match, progress=1. Repeat the test with rst_n pulsed low instead of clear: same result, and y=0 during reset.
- SEQDET_COUNT_EN with CNT_W=2, overlap=1, stream 1,0,1,0,1,0,1,0,1 (4 matches) → match_cnt counts 1,2,3,3; cnt_sat=1 from the third match; clear returns match_cnt to 0 and cnt_sat to 0.
- Compile without SEQDET_COUNT_EN and run the first scenario → identical y and progress; the counter ports do not exist.
